// File: rtl/input_word_packer.sv
// rtl/input_word_packer.sv - byte-to-word packer with word FIFO and idle timeout
//
// Packs an incoming byte stream MSB-first into 32-bit words and queues the
// words in a small FIFO. A partial word left idle for TIMEOUT cycles is
// discarded and reported by a one-cycle oDrop pulse.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-high
//   iValid  in   byte on iData is valid
//   iData   in   [7:0] input byte
//   iReady  out  packer can accept a byte this cycle
//   oData   out  [31:0] FIFO head word (0 when empty)
//   oValid  out  FIFO non-empty
//   oReady  in   consumer takes head word this cycle
//   oCount  out  [CW-1:0] words held
//   oDrop   out  one-cycle pulse: partial word discarded by timeout

module input_word_packer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iValid,
  input  logic [7:0]    iData,
  output logic          iReady,
  output logic [31:0]   oData,
  output logic          oValid,
  input  logic          oReady,
  output logic [CW-1:0] oCount,
  output logic          oDrop
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} laneT;

  laneT          lane, laneNext;
  logic          dropNext;
  logic [23:0]   partial;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [TW-1:0] idleCnt, idleNext;

  logic accept, push, pop, idle, fire;

  assign iReady = (lane != FILL3) || (count < CW'(DEPTH));
  assign accept = iValid && iReady;
  assign push   = accept && (lane == FILL3);
  assign oValid = (count != '0);
  assign pop    = oValid && oReady;
  assign oCount = count;
  assign oData  = oValid ? mem[rdPtr] : 32'h0;

  // Idle means a word is in progress and upstream offers nothing. A stalled
  // offer (iValid with iReady low) is not idle: upstream is still alive.
  assign idle = (lane != FILL0) && !iValid;
  assign fire = (TIMEOUT != 0) && idle && (idleCnt == TLAST);

  always_comb begin
    idleNext = '0;
    if (TIMEOUT != 0 && idle && !fire)
      idleNext = idleCnt + TW'(1);
  end

  // Lane FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= FILL0;
      oDrop <= 1'b0;
    end else begin
      lane  <= laneNext;
      oDrop <= dropNext;
    end
  end

  // Lane FSM: next state. Accept and timeout are mutually exclusive since a
  // timeout requires iValid=0.
  always_comb begin
    laneNext = lane;
    dropNext = 1'b0;
    if (accept) begin
      case (lane)
        FILL0:   laneNext = FILL1;
        FILL1:   laneNext = FILL2;
        FILL2:   laneNext = FILL3;
        default: laneNext = FILL0;
      endcase
    end else if (fire) begin
      laneNext = FILL0;
      dropNext = 1'b1;
    end
  end

  // Partial word: bytes 0..2 held here; byte 3 goes straight into the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial <= '0;
      idleCnt <= '0;
    end else begin
      idleCnt <= idleNext;
      if (accept) begin
        case (lane)
          FILL0:   partial[23:16] <= iData;
          FILL1:   partial[15:8]  <= iData;
          FILL2:   partial[7:0]   <= iData;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= {partial, iData};
  end

  // FIFO pointers and occupancy. A push can never hit a full FIFO because
  // iReady already blocks the 4th byte when count == DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_word_packer.sv
// tb/tb_input_word_packer.sv - scoreboard bench for input_word_packer

module tb_input_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iValid = 1'b0;
  logic [7:0]  iData = 8'h0;
  logic        iReady;
  logic [31:0] oData;
  logic        oValid;
  logic        oReady = 1'b0;
  logic [2:0]  oCount;
  logic        oDrop;

  int vectors = 0;
  int miscompares = 0;
  int dropSeen = 0;
  logic [31:0] exp[$];

  input_word_packer #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iData(iData), .iReady(iReady),
    .oData(oData), .oValid(oValid), .oReady(oReady), .oCount(oCount), .oDrop(oDrop)
  );

  always #5 clk = ~clk;

  // Monitor: compares every word the consumer takes against the scoreboard.
  always @(negedge clk) begin
    if (!rst && oDrop) dropSeen++;
    if (!rst && oValid && oReady) begin
      vectors++;
      if (exp.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got %h, scoreboard empty", oData);
      end else begin
        logic [31:0] e;
        e = exp.pop_front();
        if (oData !== e) begin
          miscompares++;
          $display("FAIL pop_data: got %h, expected %h", oData, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Offer a byte and return #1 after the edge that accepts it.
  task automatic sendByte(input logic [7:0] b);
    bit done = 0;
    iValid = 1'b1;
    iData  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (iReady) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    exp.push_back(w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
    iValid = 1'b0;
  endtask

  task automatic drain();
    oReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (oCount == 3'd0) break;
    end
    check("drain_empty", 32'(oCount), 32'd0);
    oReady = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d0;
    // Reset state
    #3;
    check("rst_oValid", 32'(oValid), 32'd0);
    check("rst_oData", oData, 32'h0);
    check("rst_oCount", 32'(oCount), 32'd0);
    check("rst_oDrop", 32'(oDrop), 32'd0);
    check("rst_iReady", 32'(iReady), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    tick(1);

    // 1: DEADBEEF, one-cycle latency, count 1 then 0
    oReady = 1'b1;
    sendWord(32'hDEADBEEF);
    check("t1_oValid", 32'(oValid), 32'd1);
    check("t1_oCount1", 32'(oCount), 32'd1);
    check("t1_oData", oData, 32'hDEADBEEF);
    tick(1);
    check("t1_oCount0", 32'(oCount), 32'd0);
    oReady = 1'b0;

    // 2: full FIFO stalls only the 4th byte
    for (int w = 1; w <= 4; w++) sendWord(32'(w));
    check("t2_full", 32'(oCount), 32'd4);
    check("t2_iReady_fill0", 32'(iReady), 32'd1);
    exp.push_back(32'h5);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    iData = 8'h05;
    check("t2_stall_iReady", 32'(iReady), 32'd0);
    tick(2);
    check("t2_stall_count", 32'(oCount), 32'd4);
    check("t2_stall_iReady2", 32'(iReady), 32'd0);
    oReady = 1'b1;
    tick(1);
    oReady = 1'b0;
    check("t2_pop_count", 32'(oCount), 32'd3);
    check("t2_pop_iReady", 32'(iReady), 32'd1);
    tick(1);
    iValid = 1'b0;
    check("t2_refill_count", 32'(oCount), 32'd4);
    drain();

    // 3: timeout drops AA,BB after 8 idle cycles
    oReady = 1'b1;
    d0 = dropSeen;
    sendByte(8'hAA); sendByte(8'hBB);
    iValid = 1'b0;
    tick(7);
    check("t3_no_drop_early", 32'(oDrop), 32'd0);
    tick(1);
    check("t3_drop", 32'(oDrop), 32'd1);
    tick(1);
    check("t3_drop_once", 32'(oDrop), 32'd0);
    tick(3);
    check("t3_drop_count", 32'(dropSeen - d0), 32'd1);
    sendWord(32'h11223344);
    tick(2);

    // 4: byte on the 8th cycle wins over the timeout
    d0 = dropSeen;
    sendByte(8'hAA);
    iValid = 1'b0;
    tick(7);
    exp.push_back(32'hAABBCCDD);
    sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD);
    iValid = 1'b0;
    tick(12);
    check("t4_no_drop", 32'(dropSeen - d0), 32'd0);
    drain();

    // 5: simultaneous push and pop keeps count and order
    sendWord(32'h01020304);
    sendWord(32'h05060708);
    check("t5_count2", 32'(oCount), 32'd2);
    exp.push_back(32'h090A0B0C);
    sendByte(8'h09); sendByte(8'h0A); sendByte(8'h0B);
    iData = 8'h0C;
    oReady = 1'b1;
    tick(1);
    oReady = 1'b0;
    iValid = 1'b0;
    check("t5_count_same", 32'(oCount), 32'd2);
    drain();

    // 6: asynchronous reset mid-word with three words held
    d0 = dropSeen;
    sendWord(32'hCAFE0001);
    sendWord(32'hCAFE0002);
    sendWord(32'hCAFE0003);
    sendByte(8'h77); sendByte(8'h88);
    iValid = 1'b0;
    check("t6_count3", 32'(oCount), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_oValid", 32'(oValid), 32'd0);
    check("t6_oData", oData, 32'h0);
    check("t6_oCount", 32'(oCount), 32'd0);
    check("t6_iReady", 32'(iReady), 32'd1);
    exp.delete();
    @(posedge clk); #1; rst = 1'b0;
    tick(12);
    check("t6_no_drop", 32'(dropSeen - d0), 32'd0);
    check("t6_still_empty", 32'(oCount), 32'd0);
    check("sb_empty", 32'(exp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
